// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//
// Purpose:
//   Multi-cycle instruction fetch and PC sequencer for a simple MIPS-style
//   core. A three-state FSM (IDLE -> FETCH -> EXEC -> FETCH ...) asks the
//   instruction memory for the word at pc, holds the returned instruction
//   while the execute stage works on it, and then moves pc to the next
//   address: jump target, taken-branch target or pc + 4.
//
// Parameters:
//   RESET_PC     PC loaded on reset. Bits [1:0] are forced to zero.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   reset        in   1   asynchronous, active-high reset
//   imem_addr    out  32  instruction memory address (always equals pc)
//   imem_req     out  1   fetch request, high only in FETCH
//   imem_ready   in   1   imem_data is valid this cycle (used only in FETCH)
//   imem_data    in   32  fetched instruction word
//   instr        out  32  registered current instruction
//   opcode       out  6   instr[31:26]
//   funct        out  6   instr[5:0]
//   instr_valid  out  1   instr is held for execution (EXEC state)
//   Beq          in   1   branch if equal      (sampled with exec_done)
//   Bne          in   1   branch if not equal  (sampled with exec_done)
//   Jump         in   1   unconditional jump   (sampled with exec_done)
//   Zero         in   1   ALU zero flag        (sampled with exec_done)
//   exec_done    in   1   execute finished (used only in EXEC)
//   pc           out  32  address of the current or pending instruction
//   pc_plus4     out  32  pc + 4, combinational
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic        instr_valid,
    input  logic        Beq,
    input  logic        Bne,
    input  logic        Jump,
    input  logic        Zero,
    input  logic        exec_done,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    // Word-aligned reset vector; the low two bits of RESET_PC are dropped.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        imem_req_q, imem_req_d;
    logic        instr_valid_q, instr_valid_d;

    logic [31:0] pc_plus4_w;
    logic [31:0] branch_off;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        branch_taken;
    logic [31:0] next_pc;

    // ------------------------------------------------------------------
    // Next-PC datapath. All additions wrap modulo 2^32. Every candidate
    // has bits [1:0] = 0 because pc is aligned and both offsets are word
    // multiples, so pc stays aligned without explicit masking.
    // ------------------------------------------------------------------
    always_comb begin
        pc_plus4_w    = pc_q + 32'd4;
        branch_off    = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        branch_target = pc_plus4_w + branch_off;
        jump_target   = {pc_plus4_w[31:28], instr_q[25:0], 2'b00};
        // Beq and Bne together always branch: the OR covers both Zero values.
        branch_taken  = (Beq & Zero) | (Bne & ~Zero);

        if (Jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end else begin
            next_pc = pc_plus4_w;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and registered-output logic. imem_req and
    // instr_valid are computed for the state being entered, so they are
    // registered alongside the state rather than decoded from it.
    // imem_ready is only looked at in FETCH and exec_done (plus the
    // branch controls feeding next_pc) only in EXEC.
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        imem_req_d    = imem_req_q;
        instr_valid_d = instr_valid_q;

        case (state_q)
            IDLE: begin
                state_d       = FETCH;
                imem_req_d    = 1'b1;
                instr_valid_d = 1'b0;
            end

            FETCH: begin
                if (imem_ready) begin
                    instr_d       = imem_data;
                    state_d       = EXEC;
                    imem_req_d    = 1'b0;
                    instr_valid_d = 1'b1;
                end
            end

            EXEC: begin
                if (exec_done) begin
                    pc_d          = next_pc;
                    state_d       = FETCH;
                    imem_req_d    = 1'b1;
                    instr_valid_d = 1'b0;
                end
            end

            default: begin
                state_d       = IDLE;
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
            end
        endcase
    end

    // Reset wins over any same-cycle imem_ready / exec_done, so an
    // in-flight fetch or execute is simply abandoned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC_ALIGNED;
            instr_q       <= 32'h0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_w;
    assign imem_addr   = pc_q;
    assign imem_req    = imem_req_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign funct       = instr_q[5:0];
    assign instr_valid = instr_valid_q;

endmodule
